alu_rr_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit `alu` datapath among `NREQ` requesters. Each requester sends an opcode and operands over a valid/ready handshake. The block grants one request at a time, registers operands and result around the ALU, and returns the result with the requester's ID on one shared valid/ready response channel. It sits between the requester front-ends and the single ALU instance, and it handles divide-by-zero itself.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 29 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_rr_sched.sv | 104 ++++++++++
 tb/tb_alu_rr_sched.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } sched_state_e;

  localparam logic [7:0] DZ_RESULT = 8'hFF;

endpackage

// File: rtl/alu.sv
// 4-bit operand ALU with 8-bit result; purely combinational datapath.
module alu
  import alu_pkg::*;
(
  input  logic [1:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] y
);

  logic [7:0] ax;
  logic [7:0] bx;

  assign ax = {4'h0, a};
  assign bx = {4'h0, b};

  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      ADD:     y = ax + bx;
      SUB:     y = ax - bx;
      MUL:     y = ax * bx;
      // b==0 yields 0 here; the scheduler substitutes its own flagged result
      DIV:     y = (b == 4'h0) ? 8'h00 : ax / bx;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  int best_dist;
  int best_k;

  // Distance from last+1 (mod NREQ); the closest active requester wins.
  always_comb begin
    best_dist = NREQ;
    best_k    = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (req[k] && (((k - int'(last) - 1 + NREQ) % NREQ) < best_dist)) begin
        best_dist = (k - int'(last) - 1 + NREQ) % NREQ;
        best_k    = k;
      end
    end
    gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      gnt[k] = (best_dist < NREQ) && (best_k == k);
    end
    idx = IDW'(best_k);
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one ALU among NREQ requesters with round-robin grant and a single
// valid/ready response channel; divide-by-zero is flagged here.
//
// state | meaning
// IDLE  | waiting for a request; grants one and latches its operands
// EXEC  | ALU evaluates latched operands; result registered
// RESP  | response held valid until rsp_ready
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0][1:0] req_op,
  input  logic [NREQ-1:0][3:0] req_a,
  input  logic [NREQ-1:0][3:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_y,
  output logic                 rsp_dz,
  output logic                 busy
);

  sched_state_e    state, state_nxt;
  logic [IDW-1:0]  last;
  logic [IDW-1:0]  gidx;
  logic [NREQ-1:0] gnt;
  alu_op_e         op_q;
  logic [3:0]      a_q, b_q;
  logic [7:0]      alu_y;
  logic            any_req;

  assign any_req = |req_valid;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req  (req_valid),
    .last (last),
    .gnt  (gnt),
    .idx  (gidx)
  );

  alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (any_req) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= IDW'(NREQ - 1);
      op_q   <= ADD;
      a_q    <= '0;
      b_q    <= '0;
      rsp_id <= '0;
      rsp_y  <= '0;
      rsp_dz <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        last   <= gidx;
        op_q   <= alu_op_e'(req_op[gidx]);
        a_q    <= req_a[gidx];
        b_q    <= req_b[gidx];
        rsp_id <= gidx;
      end
      if (state == EXEC) begin
        if (op_q == DIV && b_q == 4'h0) begin
          rsp_y  <= DZ_RESULT;
          rsp_dz <= 1'b1;
        end else begin
          rsp_y  <= alu_y;
          rsp_dz <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched with three requesters.
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int NREQ = 3;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0][1:0] req_op;
  logic [NREQ-1:0][3:0] req_a;
  logic [NREQ-1:0][3:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [7:0]           rsp_y;
  logic                 rsp_dz;
  logic                 busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           dz;
    logic [7:0]     y;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   gcyc = 0;
  int   rsp_cnt = 0;
  logic prev_v = 1'b0;

  alu_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_dz    (rsp_dz),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int id, input logic [1:0] op,
                                 input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic [7:0] x, z;
    x = {4'h0, a};
    z = {4'h0, b};
    e.id = IDW'(id);
    e.dz = 1'b0;
    case (op)
      2'b00:   e.y = x + z;
      2'b01:   e.y = x - z;
      2'b10:   e.y = x * z;
      default: begin
        if (b == 4'h0) begin
          e.y  = 8'hFF;
          e.dz = 1'b1;
        end else begin
          e.y = x / z;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor samples mid-cycle: pushes on accepted requests, pops on responses.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      sb.delete();
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) chk("latency", 32'(cyc - gcyc), 32'd2);
      prev_v = rsp_valid;
      if (rsp_valid) chk("req_ready_in_resp", 32'(req_ready), 32'd0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(model(i, req_op[i], req_a[i], req_b[i]));
          gcyc = cyc;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("rsp_y", 32'(rsp_y), 32'(mon_e.y));
          chk("rsp_dz", 32'(rsp_dz), 32'(mon_e.dz));
        end
      end
    end
  end

  task automatic send(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    @(negedge clk);
    req_op[id]    = op;
    req_a[id]     = a;
    req_b[id]     = b;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_done", 32'(n < 100), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, grants, gid, base;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_dz", 32'(rsp_dz), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(0, 2'b00, 4'hF, 4'hF);
    drain();

    send(1, 2'b01, 4'd3, 4'd5);
    send(2, 2'b10, 4'hF, 4'hF);
    send(0, 2'b11, 4'd13, 4'd4);
    send(1, 2'b11, 4'd7, 4'd0);
    drain();

    for (int k = 0; k < 8; k++) begin
      send(int'($urandom_range(0, NREQ - 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    drain();

    // Fairness: all requesters pending continuously from a fresh pointer.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = 2'b00;
      req_a[i]  = 4'(i + 1);
      req_b[i]  = 4'd1;
    end
    req_valid = '1;
    grants = 0;
    n = 0;
    while (grants < 2 * NREQ + 1 && n < 200) begin
      #1;
      if (req_ready != '0) begin
        gid = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        chk("fair_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("fair_order", 32'(gid), 32'(grants % NREQ));
        grants++;
      end
      @(negedge clk);
      n++;
    end
    req_valid = '0;
    chk("fair_grants", 32'(grants), 32'(2 * NREQ + 1));
    drain();

    // Back-pressure with a competing request pending.
    base = rsp_cnt;
    rsp_ready = 1'b0;
    send(2, 2'b10, 4'd6, 4'd7);
    #1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    req_op[0]    = 2'b00;
    req_a[0]     = 4'd1;
    req_b[0]     = 4'd1;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_y", 32'(rsp_y), 32'h2A);
      chk("bp_id", 32'(rsp_id), 32'd2);
      chk("bp_dz", 32'(rsp_dz), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    drain();
    chk("bp_rsp_count", 32'(rsp_cnt - base), 32'd2);

    // Reset while EXEC: in-flight op dropped, requester 0 first afterwards.
    base = rsp_cnt;
    send(1, 2'b00, 4'd2, 4'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_y", 32'(rsp_y), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    req_valid = '1;
    #1;
    chk("mid_rst_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    drain();
    chk("mid_rst_rsp_count", 32'(rsp_cnt - base), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
